// File: rtl/activation_arbiter_pkg.sv
// Shared definitions for the activation engine arbiter: type codes,
// fixed per-type engine latencies, FP16 constants and FSM state encoding.
package activation_pkg;

    localparam logic [3:0] ACT_NONE    = 4'd0;
    localparam logic [3:0] ACT_RELU    = 4'd1;
    localparam logic [3:0] ACT_SIGMOID = 4'd2;
    localparam logic [3:0] ACT_TANH    = 4'd3;

    // Cycles from act_start to result for a fixed-latency engine
    localparam int LAT_NONE    = 1;
    localparam int LAT_RELU    = 2;
    localparam int LAT_SIGMOID = 5;
    localparam int LAT_TANH    = 6;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    function automatic int act_latency(input logic [3:0] t);
        case (t)
            ACT_NONE:    return LAT_NONE;
            ACT_RELU:    return LAT_RELU;
            ACT_SIGMOID: return LAT_SIGMOID;
            default:     return LAT_TANH;
        endcase
    endfunction

    function automatic logic type_legal(input logic [3:0] t);
        return (t <= ACT_TANH);
    endfunction

endpackage

// File: rtl/activation_arbiter_if.sv
// Bundle of requester, engine and response signals around the arbiter.
// slave = arbiter view, master = surrounding logic (requesters/engine/sink).
interface activation_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][3:0]  req_type;
    logic [NUM_REQ-1:0][15:0] req_data;

    logic                     act_start;
    logic [3:0]               act_type;
    logic [15:0]              act_data;
    logic                     act_done;
    logic [15:0]              act_result;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [15:0]              resp_data;
    logic                     resp_err;

    modport slave (
        input  req_valid, req_type, req_data, act_done, act_result, resp_ready,
        output req_ready, act_start, act_type, act_data,
               resp_valid, resp_id, resp_data, resp_err
    );

    modport master (
        output req_valid, req_type, req_data, act_done, act_result, resp_ready,
        input  req_ready, act_start, act_type, act_data,
               resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/activation_arbiter_rr_grant.sv
// Combinational round-robin grant: first requester after i_ptr (with wrap)
// wins. Reusable by any shared-resource arbiter.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    // Scan N positions starting just after the pointer; first hit is granted
    always_comb begin
        int w_pos;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 1; k <= N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDX_W'(w_pos);
            end
        end
    end
endmodule

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one FP16 activation engine among NUM_REQ
// requesters. One operation in flight: IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro ACT_FIXED_LATENCY_EN: ignore act_done and complete
// WAIT after the per-type engine latency (no timeout possible).
module activation_arbiter
    import activation_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    activation_arbiter_if.slave bus
);
    // Wide enough for TIMEOUT and for the longest fixed latency (6)
    localparam int CNT_W = (TIMEOUT > 7) ? $clog2(TIMEOUT + 1) : 3;

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [3:0]          r_type;
    logic [15:0]         r_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_start;
    logic                r_rvalid;
    logic [15:0]         r_rdata;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_idle;
    logic                w_hs;
    logic [3:0]          w_sel_type;
    logic [15:0]         w_sel_data;
    logic                w_done;
    logic                w_tmo;

    rr_grant #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr_grant (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Ready is offered only in IDLE and is held off while reset is asserted
    assign w_idle        = (r_state == ST_IDLE) && rst_n;
    assign bus.req_ready = w_idle ? w_gnt : '0;
    assign w_hs          = w_idle && w_any;

    // Mux the granted lane's operand through the one-hot grant
    always_comb begin
        w_sel_type = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_type = bus.req_type[i];
                w_sel_data = bus.req_data[i];
            end
        end
    end

`ifdef ACT_FIXED_LATENCY_EN
    assign w_done = (r_cnt == CNT_W'(act_latency(r_type) - 1));
    assign w_tmo  = 1'b0;
`else
    assign w_done = bus.act_done;
    assign w_tmo  = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

    // Operation sequencer with registered engine and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_type   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_ptr  <= w_idx;
                        r_id   <= w_idx;
                        r_type <= w_sel_type;
                        r_data <= w_sel_data;
                        if (!type_legal(w_sel_type)) begin
                            // Illegal code never reaches the engine
                            r_rdata  <= w_sel_data;
                            r_err    <= 1'b1;
                            r_rvalid <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_rdata  <= bus.act_result;
                        r_err    <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_RESP;
                    end else if (w_tmo) begin
                        r_rdata  <= FP16_QNAN;
                        r_err    <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.act_start  = r_start;
    assign bus.act_type   = r_type;
    assign bus.act_data   = r_data;
    assign bus.resp_valid = r_rvalid;
    assign bus.resp_id    = r_id;
    assign bus.resp_data  = r_rdata;
    assign bus.resp_err   = r_err;

endmodule
